// File: rtl/packer.sv
// Signed fixed-point (sign + 1 integer bit + WIDTH fraction bits) to IEEE-754 single.
// Normalises one bit per cycle, then rounds to nearest even. Requires WIDTH >= 24.
module packer #(
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clk_en,
    input  logic             start,
    input  logic [WIDTH+1:0] dataa,
    output logic             busy,
    output logic             done,
    output logic [31:0]      result
);

    localparam int unsigned DW = WIDTH + 2;
    localparam int unsigned CW = $clog2(DW + 1);
    localparam int unsigned FW = 23;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_NORM  = 2'd1;
    localparam logic [1:0] S_ROUND = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          sgn_q, sgn_d;
    logic [DW-1:0] mag_q, mag_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   result_q, result_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [DW-1:0] abs_in;
    logic [FW-1:0] frac;
    logic          guard;
    logic          sticky;
    logic          round_up;
    logic [FW:0]   frac_sum;
    logic [7:0]    exp_val;

    // Rounding datapath: mantissa below the hidden bit, guard and sticky bits.
    always_comb begin
        abs_in   = dataa[DW-1] ? DW'(-dataa) : dataa;
        frac     = mag_q[DW-2 -: FW];
        guard    = mag_q[DW-2-FW];
        sticky   = |mag_q[DW-3-FW:0];
        round_up = guard & (sticky | frac[0]);
        frac_sum = {1'b0, frac} + (FW+1)'(round_up);
        exp_val  = 8'd128 - 8'(cnt_q) + 8'(frac_sum[FW]);
    end

    // Next-state and register update logic.
    always_comb begin
        state_d  = state_q;
        sgn_d    = sgn_q;
        mag_d    = mag_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sgn_d   = dataa[DW-1];
                    mag_d   = abs_in;
                    cnt_d   = '0;
                    state_d = (abs_in == '0) ? S_ROUND : S_NORM;
                end
            end
            S_NORM: begin
                if (mag_q[DW-1]) begin
                    state_d = S_ROUND;
                end else begin
                    mag_d = mag_q << 1;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_ROUND: begin
                // Zero input always packs as +0.
                if (mag_q == '0) begin
                    result_d = 32'h0;
                end else begin
                    result_d = {sgn_q, exp_val, frac_sum[FW] ? FW'(0) : frac_sum[FW-1:0]};
                end
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State registers; clk_en low freezes everything, including done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            sgn_q    <= 1'b0;
            mag_q    <= '0;
            cnt_q    <= '0;
            result_q <= 32'h0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (clk_en) begin
            state_q  <= state_d;
            sgn_q    <= sgn_d;
            mag_q    <= mag_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
